// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm blocks: time field limits and the
// alarm sequencer state encoding.
package clock_pkg;

    localparam int TW    = 6;
    localparam int CNT_W = 9;

    localparam logic [TW-1:0] MAX_SEC  = 6'd59;
    localparam logic [TW-1:0] MAX_MIN  = 6'd59;
    localparam logic [TW-1:0] MAX_HOUR = 6'd23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

    function automatic logic alarm_time_valid(input logic [TW-1:0] hour,
                                              input logic [TW-1:0] min);
        return (hour <= MAX_HOUR) && (min <= MAX_MIN);
    endfunction

endpackage

// File: rtl/alarm_ctrl_tone_gen.sv
// Half-period divider producing a square wave; held at zero while disabled so
// every enable window starts from a known phase.
module tone_gen #(
    parameter int HALF = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone
);

    localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cnt == W'(HALF - 1)) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: compares running time with the stored alarm, rings with a
// gated buzzer tone, supports snooze and auto-stop, drives the display DPs.
//   state     | meaning
//   ST_IDLE   | alarm disabled, outputs quiet
//   ST_ARMED  | waiting for hh:mm:00 to match the stored alarm
//   ST_RING   | buzzer active, beat toggles every second
//   ST_SNOOZE | silent, counting seconds until ringing resumes
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TONE_HZ    = 1000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] i_sec,
    input  logic [TW-1:0] i_min,
    input  logic [TW-1:0] i_hour,
    input  logic          i_set_en,
    input  logic [TW-1:0] i_set_hour,
    input  logic [TW-1:0] i_set_min,
    input  logic          i_alarm_on,
    input  logic          i_stop,
    input  logic          i_snooze,
    output logic          o_buzz,
    output logic          o_ringing,
    output logic [5:0]    o_alarm_dp,
    output logic [TW-1:0] o_alm_hour,
    output logic [TW-1:0] o_alm_min
);

    localparam int               HALF     = CLK_HZ / (2 * TONE_HZ);
    localparam logic [CNT_W-1:0] RING_END = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNZ_END  = CNT_W'(SNOOZE_SEC - 1);

    state_t           state, state_n;
    logic [TW-1:0]    sec_prev;
    logic [CNT_W-1:0] ring_cnt, ring_cnt_n;
    logic [CNT_W-1:0] snz_cnt, snz_cnt_n;
    logic             beat, beat_n;
    logic             tone;
    logic             sec_tick;
    logic             match;

    assign sec_tick = (i_sec != sec_prev);
    assign match    = sec_tick && (i_sec == '0) &&
                      (i_min == o_alm_min) && (i_hour == o_alm_hour);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sec_prev   <= '0;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            beat       <= 1'b0;
            o_alm_hour <= '0;
            o_alm_min  <= '0;
        end else begin
            state    <= state_n;
            sec_prev <= i_sec;
            ring_cnt <= ring_cnt_n;
            snz_cnt  <= snz_cnt_n;
            beat     <= beat_n;
            if (i_set_en && alarm_time_valid(i_set_hour, i_set_min)) begin
                o_alm_hour <= i_set_hour;
                o_alm_min  <= i_set_min;
            end
        end
    end

    // Counters only advance below their end value, so they saturate by construction.
    always_comb begin
        state_n    = state;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        beat_n     = beat;
        if (!i_alarm_on) begin
            state_n    = ST_IDLE;
            ring_cnt_n = '0;
            snz_cnt_n  = '0;
            beat_n     = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_ARMED;
                ST_ARMED: begin
                    if (match) begin
                        state_n    = ST_RING;
                        ring_cnt_n = '0;
                        beat_n     = 1'b1;
                    end
                end
                ST_RING: begin
                    if (i_stop) begin
                        state_n = ST_ARMED;
                    end else if (i_snooze) begin
                        state_n   = ST_SNOOZE;
                        snz_cnt_n = '0;
                    end else if (sec_tick) begin
                        beat_n = ~beat;
                        if (ring_cnt >= RING_END) state_n = ST_ARMED;
                        else                      ring_cnt_n = ring_cnt + 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (i_stop) begin
                        state_n = ST_ARMED;
                    end else if (sec_tick) begin
                        if (snz_cnt >= SNZ_END) begin
                            state_n    = ST_RING;
                            ring_cnt_n = '0;
                            beat_n     = 1'b1;
                        end else begin
                            snz_cnt_n = snz_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    tone_gen #(.HALF(HALF)) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_RING),
        .tone  (tone)
    );

    // Buzz is also gated by state so a tone edge on the exit clock never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_buzz     <= 1'b0;
            o_ringing  <= 1'b0;
            o_alarm_dp <= '0;
        end else begin
            o_buzz    <= tone & beat & (state == ST_RING);
            o_ringing <= (state == ST_RING);
            unique case (state)
                ST_ARMED, ST_SNOOZE: o_alarm_dp <= 6'b000001;
                ST_RING:             o_alarm_dp <= {6{beat}};
                default:             o_alarm_dp <= '0;
            endcase
        end
    end

endmodule
